mem_arbiter: RTL and testbench

Three-requester arbiter and sequencer for the single `byte_addressable` memory port. It shares that port between instruction fetch, data load/store and the switch/debug loader. For each transaction it drives address, write size and write data, waits the fixed read latency or the write `done` handshake, and returns read data or an error to the winning requester. It sits between the core FSM and the memory, replacing direct `memory_address`/`write_en` muxing in the top level.

---
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-requester arbiter/sequencer for the shared byte-addressable memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed debug > data > fetch.
module mem_arbiter #(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned WR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [95:0] req_addr,
    input  logic [5:0]  req_wsize,
    input  logic [95:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_error,
    output logic        busy,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue  = 3'd1,
        StWaitRd = 3'd2,
        StWaitWr = 3'd3,
        StResp   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  wsize_q, wsize_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        done_seen_q, done_seen_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        any_req;
    logic [1:0]  win;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign any_req = |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;
    logic [1:0] rr_first, rr_second;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // rr_q holds the last winner; it becomes the lowest-priority requester.
    always_comb begin
        rr_first  = rr_next(rr_q);
        rr_second = rr_next(rr_first);
        win       = rr_q;
        if (req[rr_first]) begin
            win = rr_first;
        end else if (req[rr_second]) begin
            win = rr_second;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == StIdle && any_req) begin
            rr_d = win;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        if (req[2]) begin
            win = 2'd2;
        end else if (req[1]) begin
            win = 2'd1;
        end else begin
            win = 2'd0;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wsize_d     = wsize_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        done_seen_d = done_seen_q;
        lat_cnt_d   = lat_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d     = win;
                    addr_d      = req_addr[{win, 5'd0} +: 32];
                    wsize_d     = req_wsize[{win, 1'b0} +: 2];
                    wdata_d     = req_wdata[{win, 5'd0} +: 32];
                    err_d       = 1'b0;
                    done_seen_d = 1'b0;
                    lat_cnt_d   = 3'd0;
                    wr_cnt_d    = 8'd0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // A done already seen here still ends the write after one WAIT_WR cycle.
                done_seen_d = mem_done;
                if (mem_error) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (wsize_q == 2'b00) begin
                    state_d = StWaitRd;
                end else begin
                    state_d = StWaitWr;
                end
            end
            StWaitRd: begin
                if (lat_cnt_q == 3'(READ_LAT - 1)) begin
                    rdata_d = mem_rdata;
                    state_d = StResp;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StWaitWr: begin
                if (done_seen_q || mem_done) begin
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (wr_cnt_q == 8'(WR_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wr_cnt_d = wr_cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= 2'd0;
            addr_q      <= 32'd0;
            wsize_q     <= 2'b00;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            done_seen_q <= 1'b0;
            lat_cnt_q   <= 3'd0;
            wr_cnt_q    <= 8'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wsize_q     <= wsize_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            done_seen_q <= done_seen_d;
            lat_cnt_q   <= lat_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Strobes are decoded from state so nothing combinational reaches them from req.
    always_comb begin
        gnt       = 3'b000;
        rsp_valid = 3'b000;
        rsp_err   = 1'b0;
        mem_write = 2'b00;
        case (state_q)
            StIssue: begin
                gnt       = onehot(owner_q);
                mem_write = wsize_q;
            end
            StWaitWr: begin
                mem_write = wsize_q;
            end
            StResp: begin
                rsp_valid = onehot(owner_q);
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign busy      = (state_q != StIdle);
    assign state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural memory device, reference memory and arbitration model.
module tb_mem_arbiter;

    localparam int unsigned RL = 1;
    localparam int unsigned WT = 15;

    logic        clk, rst;
    logic [2:0]  req;
    logic [95:0] req_addr;
    logic [5:0]  req_wsize;
    logic [95:0] req_wdata;
    logic [2:0]  gnt, rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_write;
    logic        mem_done, mem_error, busy;
    logic [2:0]  state;

    mem_arbiter #(.READ_LAT(RL), .WR_TIMEOUT(WT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_wsize (req_wsize),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_error (mem_error),
        .busy      (busy),
        .state     (state)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_last = 0;
    int done_delay = 255;

    typedef struct {
        logic [2:0]  g;
        int          cyc;
        logic [1:0]  ws;
        logic [31:0] addr;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        logic [2:0]  v;
        logic        err;
        logic [31:0] rd;
        logic        rd_chk;
        int          cyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    logic [7:0]  ref_mem [0:255];
    logic [7:0]  dev_mem [0:255];
    logic [31:0] rd_pipe [0:RL-1];
    int          wcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16:      return 8'h93;
            17:      return 8'h00;
            18:      return 8'h50;
            19:      return 8'h00;
            default: return 8'(i * 29 + 7);
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] ws);
        case (ws)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] ws, input logic [31:0] a);
        return (ws == 2'b11 && a[1:0] != 2'b00) || (ws == 2'b10 && a[0]);
    endfunction

    // Memory device: READ_LAT-deep read pipe, done after done_delay cycles of a write.
    assign mem_error = misaligned(mem_write, mem_addr);
    assign mem_done  = (mem_write != 2'b00) && !mem_error && (wcnt == done_delay);
    assign mem_rdata = rd_pipe[RL-1];

    initial begin
        for (int i = 0; i < 256; i++) dev_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            rd_pipe[0] <= {dev_mem[mem_addr[7:0] + 8'd3], dev_mem[mem_addr[7:0] + 8'd2],
                           dev_mem[mem_addr[7:0] + 8'd1], dev_mem[mem_addr[7:0]]};
            for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
            wcnt <= (mem_write != 2'b00 && !mem_error) ? wcnt + 1 : 0;
            if (mem_done) begin
                for (int b = 0; b < nbytes(mem_write); b++) begin
                    dev_mem[mem_addr[7:0] + 8'(b)] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [7:0] a;
        a = addr[7:0];
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [1:0] ws, input logic [31:0] wd);
        for (int b = 0; b < nbytes(ws); b++) ref_mem[addr[7:0] + 8'(b)] = wd[8*b +: 8];
    endtask

    function automatic int pick(input logic [2:0] pend, input int last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 3; i++) begin
            if (pend[(last + i) % 3]) return (last + i) % 3;
        end
        return last;
`else
        if (pend[2]) return 2;
        if (pend[1]) return 1;
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or a response.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (rst) begin
            if (gnt != 3'b000) begin
                if (gq.size() == 0) begin
                    fail("unexpected_gnt");
                end else begin
                    ge = gq.pop_front();
                    check("gnt", 32'(gnt), 32'(ge.g));
                    check("gnt_cycle", cyc, ge.cyc);
                    check("issue_addr", mem_addr, ge.addr);
                    check("issue_write", 32'(mem_write), 32'(ge.ws));
                    if (ge.ws != 2'b00) check("issue_wdata", mem_wdata, ge.wd);
                end
            end
            if (rsp_valid != 3'b000) begin
                if (rq.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    re = rq.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(re.v));
                    check("rsp_err", 32'(rsp_err), 32'(re.err));
                    check("rsp_cycle", cyc, re.cyc);
                    check("resp_mem_write", 32'(mem_write), 32'd0);
                    check("resp_busy", 32'(busy), 32'd1);
                    if (re.rd_chk) check("rsp_rdata", rsp_rdata, re.rd);
                end
            end
        end
    end

    task automatic wait_gq();
        for (int i = 0; i < 60 && gq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (gq.size() != 0) begin
            fail("gnt_timeout");
            gq.delete();
        end
    endtask

    task automatic wait_rq();
        for (int i = 0; i < 60 && rq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (rq.size() != 0) begin
            fail("rsp_timeout");
            rq.delete();
        end
        @(negedge clk);
    endtask

    task automatic scramble();
        req_addr  = {$urandom, $urandom, $urandom};
        req_wsize = 6'($urandom);
        req_wdata = {$urandom, $urandom, $urandom};
    endtask

    // One transaction from requester k; called at a negedge with the DUT idle.
    task automatic do_single(input int k, input logic [31:0] addr, input logic [1:0] ws,
                             input logic [31:0] wd, input int dly);
        gexp_t ge;
        rexp_t re;
        int    resp;
        logic  err;
        err       = misaligned(ws, addr);
        re.rd     = 32'h0;
        re.rd_chk = 1'b0;
        if (ws == 2'b00) begin
            resp      = 2 + RL;
            re.rd     = ref_word(addr);
            re.rd_chk = 1'b1;
        end else if (err) begin
            resp = 2;
        end else if (dly <= WT) begin
            resp = (dly < 1) ? 3 : 2 + dly;
            ref_write(addr, ws, wd);
        end else begin
            resp = 2 + WT;
            err  = 1'b1;
        end
        ge.g    = 3'b001 << k;
        ge.cyc  = cyc + 1;
        ge.ws   = ws;
        ge.addr = addr;
        ge.wd   = wd;
        re.v    = 3'b001 << k;
        re.err  = err;
        re.cyc  = cyc + resp;
        gq.push_back(ge);
        rq.push_back(re);
        done_delay = dly;
        scramble();
        req_addr[32*k +: 32] = addr;
        req_wsize[2*k +: 2]  = ws;
        req_wdata[32*k +: 32] = wd;
        req = 3'b001 << k;
        wait_gq();
        req = 3'b000;
        scramble();
        wait_rq();
    endtask

    // Requesters in mask issue reads together and each drops req once granted.
    task automatic do_arb(input logic [2:0] mask, input int hold_grants);
        gexp_t       ge;
        rexp_t       re;
        logic [2:0]  pend;
        logic [31:0] addrs [0:2];
        int          t, w, n, cnt;
        scramble();
        for (int k = 0; k < 3; k++) begin
            addrs[k] = $urandom_range(0, 60);
            req_addr[32*k +: 32] = addrs[k];
            if (mask[k]) req_wsize[2*k +: 2] = 2'b00;
        end
        pend = mask;
        t    = cyc + 1;
        n    = (hold_grants > 0) ? hold_grants : 3;
        for (int g = 0; g < n && pend != 3'b000; g++) begin
            w       = pick(pend, model_last);
            ge.g    = 3'b001 << w;
            ge.cyc  = t;
            ge.ws   = 2'b00;
            ge.addr = addrs[w];
            ge.wd   = 32'h0;
            re.v    = 3'b001 << w;
            re.err  = 1'b0;
            re.rd   = ref_word(addrs[w]);
            re.rd_chk = 1'b1;
            re.cyc  = t + 1 + RL;
            gq.push_back(ge);
            rq.push_back(re);
            if (hold_grants == 0) pend[w] = 1'b0;
            model_last = w;
            t = t + RL + 3;
        end
        req = mask;
        cnt = 0;
        for (int i = 0; i < 300 && req != 3'b000; i++) begin
            @(negedge clk);
            #1;
            if (gnt != 3'b000) cnt++;
            if (hold_grants == 0) req = req & ~gnt;
            else if (cnt >= hold_grants) req = 3'b000;
        end
        if (req != 3'b000) begin
            fail("arb_timeout");
            req = 3'b000;
            gq.delete();
        end
        wait_gq();
        wait_rq();
    endtask

    // Reset asserted mid WAIT_WR: outputs clear at once and the write never responds.
    task automatic do_reset_mid();
        gexp_t ge;
        ge.g    = 3'b010;
        ge.cyc  = cyc + 1;
        ge.ws   = 2'b11;
        ge.addr = 32'h40;
        ge.wd   = 32'hCAFEF00D;
        gq.push_back(ge);
        done_delay = 255;
        scramble();
        req_addr[63:32]  = 32'h40;
        req_wsize[3:2]   = 2'b11;
        req_wdata[63:32] = 32'hCAFEF00D;
        req = 3'b010;
        wait_gq();
        req = 3'b000;
        model_last = 1;
        repeat (3) @(negedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_write", 32'(mem_write), 32'd3);
        rst = 1'b0;
        #1;
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_last = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req       = 3'b000;
        req_addr  = '0;
        req_wsize = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        #2;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_single(0, 32'h10, 2'b00, 32'h0, 0);
        do_single(1, 32'h20, 2'b11, 32'hDEADBEEF, 4);
        do_single(0, 32'h20, 2'b00, 32'h0, 0);
        model_last = 0;
        do_arb(3'b111, 6);
        do_single(1, 32'h22, 2'b11, 32'h12345678, 0);
        do_single(0, 32'h20, 2'b00, 32'h0, 0);
        do_single(2, 32'h30, 2'b11, 32'hA5A5A5A5, 255);
        do_single(2, 32'h30, 2'b10, 32'h0000BEEF, 0);
        do_single(1, 32'h34, 2'b01, 32'h00000077, 15);
        do_single(1, 32'h38, 2'b11, 32'h0BADF00D, 16);
        do_single(0, 32'h30, 2'b00, 32'h0, 0);
        do_single(0, 32'h34, 2'b00, 32'h0, 0);
        do_single(0, 32'h38, 2'b00, 32'h0, 0);

        do_reset_mid();
        do_arb(3'b111, 3);
        do_single(1, 32'h40, 2'b00, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            int          k, dly;
            logic [1:0]  ws;
            logic [31:0] addr;
            k    = $urandom_range(0, 2);
            ws   = 2'($urandom_range(0, 3));
            addr = $urandom_range(0, 60);
            dly  = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 5);
            do_single(k, addr, ws, $urandom, dly);
        end
        for (int n = 0; n < 15; n++) begin
            do_arb(3'($urandom_range(1, 7)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
